rlc_game_system_sysinfo: RTL and testbench

Parametrised system-information slave on the RLC game system's Avalon-MM interconnect. It serves build ID, build timestamp and a capability word, plus a 64-bit uptime counter with atomic snapshot reads and byte-writable scratch registers. Reads have fixed, configurable latency via `readdatavalid`. Software uses it to identify the image, measure elapsed cycles and confirm the bus path.

---
 rtl/rlc_sysinfo_pkg.sv | 54 +++++
 rtl/rlc_sysinfo_uptime.sv | 67 ++++++
 rtl/rlc_game_system_sysinfo.sv | 153 +++++++++++++++
 tb/tb_rlc_game_system_sysinfo.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rlc_sysinfo_pkg.sv
// Shared register map, CTRL/CAPS field positions and helpers for the
// RLC game system sysinfo slave.
package rlc_sysinfo_pkg;

  localparam logic [3:0] OFF_ID        = 4'd0;
  localparam logic [3:0] OFF_TS        = 4'd1;
  localparam logic [3:0] OFF_CAPS      = 4'd2;
  localparam logic [3:0] OFF_CTRL      = 4'd3;
  localparam logic [3:0] OFF_UPTIME_LO = 4'd4;
  localparam logic [3:0] OFF_UPTIME_HI = 4'd5;
  localparam logic [3:0] OFF_SCRATCH0  = 4'd6;

  localparam int CTRL_FREEZE  = 0;
  localparam int CTRL_CLEAR   = 1;
  localparam int CTRL_WRAP    = 8;
  localparam int CTRL_COLLIDE = 9;

  localparam int CAPS_VERSION_LSB  = 0;
  localparam int CAPS_NSCRATCH_LSB = 8;
  localparam int CAPS_LATENCY_LSB  = 12;

  localparam logic [7:0] SYSINFO_VERSION = 8'h02;

  typedef struct packed {
    logic clear;
    logic freeze_we;
    logic freeze_val;
    logic snap;
  } uptime_ctl_t;

  function automatic logic [31:0] caps_word(input int num_scratch, input int read_latency);
    logic [31:0] w;
    w = 32'h0000_0000;
    w[CAPS_VERSION_LSB +: 8]  = SYSINFO_VERSION;
    w[CAPS_NSCRATCH_LSB +: 4] = 4'(num_scratch);
    w[CAPS_LATENCY_LSB +: 2]  = 2'(read_latency);
    return w;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        m[8*b +: 8] = new_w[8*b +: 8];
      end else begin
        m[8*b +: 8] = old_w[8*b +: 8];
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/rlc_sysinfo_uptime.sv
// 64-bit uptime counter with freeze, clear, wrap detection and the
// high-half snapshot captured by reads of UPTIME_LO.
module rlc_sysinfo_uptime
  import rlc_sysinfo_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  uptime_ctl_t ctl_i,
  output logic [31:0] count_lo_o,
  output logic [31:0] snap_hi_o,
  output logic        freeze_o,
  output logic        wrap_o
);

  logic [63:0] cnt_q, cnt_d;
  logic [31:0] snap_hi_q, snap_hi_d;
  logic        freeze_q, freeze_d;
  logic        wrap_s;

  // Counter next state: clear beats increment, freeze uses the pre-edge value.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_s = 1'b0;
    if (ctl_i.clear) begin
      cnt_d = 64'h0;
    end else if (!freeze_q) begin
      cnt_d  = cnt_q + 64'd1;
      wrap_s = (cnt_q == 64'hFFFF_FFFF_FFFF_FFFF);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // The low half of a snapshot is returned by the capturing read itself,
  // so only the high half needs to be held for a later UPTIME_HI read.
  always_comb begin
    if (ctl_i.freeze_we) begin
      freeze_d = ctl_i.freeze_val;
    end else begin
      freeze_d = freeze_q;
    end
    if (ctl_i.snap) begin
      snap_hi_d = cnt_q[63:32];
    end else begin
      snap_hi_d = snap_hi_q;
    end
  end

  // State registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= 64'h0;
      snap_hi_q <= 32'h0;
      freeze_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      snap_hi_q <= snap_hi_d;
      freeze_q  <= freeze_d;
    end
  end

  assign count_lo_o = cnt_q[31:0];
  assign snap_hi_o  = snap_hi_q;
  assign freeze_o   = freeze_q;
  assign wrap_o     = wrap_s;

endmodule

// File: rtl/rlc_game_system_sysinfo.sv
// System-information Avalon-MM slave: ID/timestamp/caps, CTRL/STATUS,
// uptime with snapshot reads, byte-writable scratch and fixed read latency.
module rlc_game_system_sysinfo
  import rlc_sysinfo_pkg::*;
#(
  parameter logic [31:0] SYS_ID       = 32'h0000_0000,
  parameter logic [31:0] BUILD_TS     = 32'h0000_0000,
  parameter int          NUM_SCRATCH  = 4,
  parameter int          READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  logic        wr_ok_s, collide_s, ctrl_we_s;
  logic        wrap_w1c_s, collide_w1c_s;
  uptime_ctl_t ctl_s;
  logic [31:0] count_lo_s, snap_hi_s, ctrl_word_s, rdata_s, rd_dat_d;
  logic        freeze_s, wrap_pulse_s;
  logic        wrap_q, wrap_d, collide_q, collide_d;
  logic [31:0] scratch_q [NUM_SCRATCH];
  logic [31:0] scratch_d [NUM_SCRATCH];
  logic [READ_LATENCY-1:0] vld_q;
  logic [31:0] dat_q [READ_LATENCY];

  // Write decode: a write paired with a read is dropped and flagged.
  always_comb begin
    wr_ok_s       = write && !read;
    collide_s     = write && read;
    ctrl_we_s     = wr_ok_s && (address == OFF_CTRL);
    ctl_s.freeze_we  = ctrl_we_s && byteenable[0];
    ctl_s.freeze_val = writedata[CTRL_FREEZE];
    ctl_s.clear      = ctrl_we_s && byteenable[0] && writedata[CTRL_CLEAR];
    ctl_s.snap       = read && (address == OFF_UPTIME_LO);
    wrap_w1c_s    = ctrl_we_s && byteenable[1] && writedata[CTRL_WRAP];
    collide_w1c_s = ctrl_we_s && byteenable[1] && writedata[CTRL_COLLIDE];
  end

  rlc_sysinfo_uptime u_uptime (
    .clock      (clock),
    .reset_n    (reset_n),
    .ctl_i      (ctl_s),
    .count_lo_o (count_lo_s),
    .snap_hi_o  (snap_hi_s),
    .freeze_o   (freeze_s),
    .wrap_o     (wrap_pulse_s)
  );

  // Sticky status: a set event in the same cycle wins over write-1-to-clear.
  always_comb begin
    if (wrap_pulse_s) begin
      wrap_d = 1'b1;
    end else if (wrap_w1c_s) begin
      wrap_d = 1'b0;
    end else begin
      wrap_d = wrap_q;
    end
    if (collide_s) begin
      collide_d = 1'b1;
    end else if (collide_w1c_s) begin
      collide_d = 1'b0;
    end else begin
      collide_d = collide_q;
    end
  end

  // Scratch byte-lane writes.
  always_comb begin
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      if (wr_ok_s && (address == OFF_SCRATCH0 + 4'(i))) begin
        scratch_d[i] = merge_bytes(scratch_q[i], writedata, byteenable);
      end else begin
        scratch_d[i] = scratch_q[i];
      end
    end
  end

  // Read mux, evaluated on pre-edge state of the acceptance cycle.
  always_comb begin
    ctrl_word_s               = 32'h0000_0000;
    ctrl_word_s[CTRL_FREEZE]  = freeze_s;
    ctrl_word_s[CTRL_WRAP]    = wrap_q;
    ctrl_word_s[CTRL_COLLIDE] = collide_q;
    rdata_s = 32'h0000_0000;
    case (address)
      OFF_ID:        rdata_s = SYS_ID;
      OFF_TS:        rdata_s = BUILD_TS;
      OFF_CAPS:      rdata_s = caps_word(NUM_SCRATCH, READ_LATENCY);
      OFF_CTRL:      rdata_s = ctrl_word_s;
      OFF_UPTIME_LO: rdata_s = count_lo_s;
      OFF_UPTIME_HI: rdata_s = snap_hi_s;
      default: begin
        for (int i = 0; i < NUM_SCRATCH; i++) begin
          if (address == OFF_SCRATCH0 + 4'(i)) begin
            rdata_s = scratch_q[i];
          end else begin
            rdata_s = rdata_s;
          end
        end
      end
    endcase
    if (read) begin
      rd_dat_d = rdata_s;
    end else begin
      rd_dat_d = 32'h0000_0000;
    end
  end

  // Registers for sticky bits and scratch.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wrap_q    <= 1'b0;
      collide_q <= 1'b0;
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        scratch_q[i] <= 32'h0000_0000;
      end
    end else begin
      wrap_q    <= wrap_d;
      collide_q <= collide_d;
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        scratch_q[i] <= scratch_d[i];
      end
    end
  end

  // Read pipeline; data is zeroed in non-valid slots so the bus idles at 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= {READ_LATENCY{1'b0}};
      for (int k = 0; k < READ_LATENCY; k++) begin
        dat_q[k] <= 32'h0000_0000;
      end
    end else begin
      vld_q[0] <= read;
      dat_q[0] <= rd_dat_d;
      for (int k = 1; k < READ_LATENCY; k++) begin
        vld_q[k] <= vld_q[k-1];
        dat_q[k] <= dat_q[k-1];
      end
    end
  end

  assign readdata      = dat_q[READ_LATENCY-1];
  assign readdatavalid = vld_q[READ_LATENCY-1];

endmodule

// File: tb/tb_rlc_game_system_sysinfo.sv
// Bench: two sysinfo instances (latency 1 and 2) on one bus, checked every
// cycle against a register-level model plus directed literal expectations.
module tb_rlc_game_system_sysinfo;

  localparam logic [31:0] SYS_ID   = 32'h1234_5678;
  localparam logic [31:0] BUILD_TS = 32'h6512_3456;
  localparam int          NS       = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  address;
  logic        read, write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] rdata1, rdata2;
  logic        rvalid1, rvalid2;

  always #5 clock = ~clock;

  rlc_game_system_sysinfo #(.SYS_ID(SYS_ID), .BUILD_TS(BUILD_TS),
                            .NUM_SCRATCH(NS), .READ_LATENCY(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .address(address), .read(read),
    .write(write), .writedata(writedata), .byteenable(byteenable),
    .readdata(rdata1), .readdatavalid(rvalid1));

  rlc_game_system_sysinfo #(.SYS_ID(SYS_ID), .BUILD_TS(BUILD_TS),
                            .NUM_SCRATCH(NS), .READ_LATENCY(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .address(address), .read(read),
    .write(write), .writedata(writedata), .byteenable(byteenable),
    .readdata(rdata2), .readdatavalid(rvalid2));

  typedef struct { int acc; logic [31:0] d; } exp_t;
  exp_t q1[$];
  exp_t q2[$];

  logic [63:0] m_cnt, m_snap;
  logic        m_freeze, m_wrap, m_collide;
  logic [31:0] m_scr [NS];
  int cyc = 0;
  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] a, input int lat);
    int ai;
    ai = int'(a);
    if (ai == 0) return SYS_ID;
    if (ai == 1) return BUILD_TS;
    if (ai == 2) return {18'h0, 2'(lat), 4'(NS), 8'h02};
    if (ai == 3) return {22'h0, m_collide, m_wrap, 7'h0, m_freeze};
    if (ai == 4) return m_cnt[31:0];
    if (ai == 5) return m_snap[63:32];
    if (ai >= 6 && ai < 6 + NS) return m_scr[ai-6];
    return 32'h0;
  endfunction

  task automatic model_clear();
    m_cnt = 64'h0; m_snap = 64'h0;
    m_freeze = 1'b0; m_wrap = 1'b0; m_collide = 1'b0;
    for (int i = 0; i < NS; i++) m_scr[i] = 32'h0;
    q1.delete(); q2.delete();
  endtask

  // Model: apply one bus cycle at each rising edge from the pre-edge state.
  always @(posedge clock) begin
    logic old_f, clr;
    int ai;
    cyc++;
    if (reset_n) begin
      old_f = m_freeze; clr = 1'b0; ai = int'(address);
      if (read) begin
        q1.push_back('{cyc, model_read(address, 1)});
        q2.push_back('{cyc, model_read(address, 2)});
        if (ai == 4) m_snap = m_cnt;
      end
      if (read && write) m_collide = 1'b1;
      else if (write) begin
        if (ai == 3) begin
          if (byteenable[0]) begin m_freeze = writedata[0]; clr = writedata[1]; end
          if (byteenable[1]) begin
            if (writedata[8]) m_wrap = 1'b0;
            if (writedata[9]) m_collide = 1'b0;
          end
        end else if (ai >= 6 && ai < 6 + NS) begin
          for (int b = 0; b < 4; b++)
            if (byteenable[b]) m_scr[ai-6][8*b +: 8] = writedata[8*b +: 8];
        end
      end
      if (clr) m_cnt = 64'h0;
      else if (!old_f) begin
        if (m_cnt == 64'hFFFF_FFFF_FFFF_FFFF) m_wrap = 1'b1;
        m_cnt = m_cnt + 64'd1;
      end
    end
  end

  task automatic cmp_one(input string nm, input int lat, input logic v, input logic [31:0] d,
                         input bit have, input int acc, input logic [31:0] ed, output bit pop);
    bit exp_v;
    exp_v = have && (acc + lat - 1 == cyc);
    chk({nm, " valid"}, {31'h0, v}, {31'h0, exp_v});
    if (exp_v) chk({nm, " data"}, d, ed);
    else chk({nm, " idle data"}, d, 32'h0);
    pop = exp_v || (have && (acc + lat - 1 < cyc));
  endtask

  // Compare both instances against the model on every falling edge.
  always @(negedge clock) begin
    bit h, p;
    h = (q1.size() > 0);
    cmp_one("dut1", 1, rvalid1, rdata1, h, h ? q1[0].acc : 0, h ? q1[0].d : 32'h0, p);
    if (p) void'(q1.pop_front());
    h = (q2.size() > 0);
    cmp_one("dut2", 2, rvalid2, rdata2, h, h ? q2[0].acc : 0, h ? q2[0].d : 32'h0, p);
    if (p) void'(q2.pop_front());
  end

  task automatic bus(input logic rd, input logic wr, input logic [3:0] a,
                     input logic [31:0] wd, input logic [3:0] be);
    @(negedge clock);
    read = rd; write = wr; address = a; writedata = wd; byteenable = be;
    @(posedge clock);
    #1;
    read = 1'b0; write = 1'b0; address = 4'h0; writedata = 32'h0; byteenable = 4'h0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] wd, input logic [3:0] be);
    bus(1'b0, 1'b1, a, wd, be);
  endtask

  task automatic rd(input logic [3:0] a);
    bus(1'b1, 1'b0, a, 32'h0, 4'h0);
  endtask

  task automatic rd_chk(input string nm, input logic [3:0] a, input logic [31:0] lit);
    rd(a);
    @(negedge clock);
    chk({nm, " rdv"}, {31'h0, rvalid1}, 32'h1);
    chk(nm, rdata1, lit);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    read = 1'b0; write = 1'b0; address = 4'h0; writedata = 32'h0; byteenable = 4'h0;
    reset_n = 1'b1;
    model_clear();
    #1 reset_n = 1'b0;
    @(negedge clock);
    chk("reset rdv1", {31'h0, rvalid1}, 32'h0);
    chk("reset rdata2", rdata2, 32'h0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    rd_chk("id", 4'd0, 32'h1234_5678);
    rd_chk("caps", 4'd2, 32'h0000_1402);
    rd_chk("scr1 after reset", 4'd7, 32'h0);
    rd_chk("ts", 4'd1, 32'h6512_3456);
    rd_chk("unmapped14", 4'd14, 32'h0);

    wr(4'd6, 32'hAABB_CCDD, 4'b1111);
    wr(4'd6, 32'h0000_0011, 4'b0001);
    rd_chk("scratch be", 4'd6, 32'hAABB_CC11);
    wr(4'd9, 32'hDEAD_BEEF, 4'b1010);
    rd_chk("last scratch", 4'd9, 32'hDE00_BE00);
    wr(4'd10, 32'hFFFF_FFFF, 4'b1111);
    rd_chk("unmapped10", 4'd10, 32'h0);
    wr(4'd0, 32'hFFFF_FFFF, 4'b1111);
    rd_chk("ro id", 4'd0, 32'h1234_5678);

    wr(4'd3, 32'h0000_0003, 4'b1111);
    idle(5);
    rd_chk("clear lo", 4'd4, 32'h0);
    rd_chk("ctrl frozen", 4'd3, 32'h0000_0001);
    rd_chk("hi never big", 4'd5, 32'h0);
    wr(4'd3, 32'h0, 4'b1111);
    idle(7);
    wr(4'd3, 32'h0000_0001, 4'b1111);
    rd_chk("freeze lo a", 4'd4, 32'd8);
    idle(20);
    rd_chk("freeze lo b", 4'd4, 32'd8);

    force dut1.u_uptime.cnt_q = 64'hFFFF_FFFF_FFFF_FFFE;
    force dut2.u_uptime.cnt_q = 64'hFFFF_FFFF_FFFF_FFFE;
    m_cnt = 64'hFFFF_FFFF_FFFF_FFFE;
    idle(2);
    release dut1.u_uptime.cnt_q;
    release dut2.u_uptime.cnt_q;
    wr(4'd3, 32'h0, 4'b1111);
    idle(2);
    rd_chk("wrap lo", 4'd4, 32'h0);
    rd_chk("wrap ctrl", 4'd3, 32'h0000_0100);
    wr(4'd3, 32'h0000_0100, 4'b1111);
    rd_chk("wrap w1c", 4'd3, 32'h0);

    wr(4'd3, 32'h0000_0001, 4'b1111);
    force dut1.u_uptime.cnt_q = 64'h0000_0001_FFFF_FFF0;
    force dut2.u_uptime.cnt_q = 64'h0000_0001_FFFF_FFF0;
    m_cnt = 64'h0000_0001_FFFF_FFF0;
    idle(2);
    release dut1.u_uptime.cnt_q;
    release dut2.u_uptime.cnt_q;
    wr(4'd3, 32'h0, 4'b1111);
    rd_chk("snap lo", 4'd4, 32'hFFFF_FFF0);
    idle(20);
    rd_chk("snap hi", 4'd5, 32'h0000_0001);

    wr(4'd3, 32'h0000_0001, 4'b1111);
    force dut1.u_uptime.cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
    force dut2.u_uptime.cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
    m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    idle(2);
    release dut1.u_uptime.cnt_q;
    release dut2.u_uptime.cnt_q;
    wr(4'd3, 32'h0, 4'b1111);
    wr(4'd3, 32'h0000_0100, 4'b1111);
    rd_chk("wrap set wins", 4'd3, 32'h0000_0100);
    wr(4'd3, 32'h0000_0100, 4'b1111);

    bus(1'b1, 1'b1, 4'd6, 32'h1111_1111, 4'b1111);
    @(negedge clock);
    chk("collide read", rdata1, 32'hAABB_CC11);
    rd_chk("collide scratch", 4'd6, 32'hAABB_CC11);
    rd_chk("collide ctrl", 4'd3, 32'h0000_0200);
    wr(4'd3, 32'h0000_0200, 4'b1111);
    rd_chk("collide w1c", 4'd3, 32'h0);

    rd(4'd0); rd(4'd1); rd(4'd2); rd(4'd6);
    @(negedge clock);
    chk("pipe3 lat2 valid", {31'h0, rvalid2}, 32'h1);
    chk("pipe3 lat2 data", rdata2, 32'h0000_2402);
    @(negedge clock);
    chk("pipe4 lat2 valid", {31'h0, rvalid2}, 32'h1);
    chk("pipe4 lat2 data", rdata2, 32'hAABB_CC11);

    @(negedge clock);
    read = 1'b1; address = 4'd6;
    @(posedge clock);
    #1;
    read = 1'b0; address = 4'h0;
    reset_n = 1'b0;
    model_clear();
    @(negedge clock);
    chk("midreset rdv1", {31'h0, rvalid1}, 32'h0);
    chk("midreset rdv2", {31'h0, rvalid2}, 32'h0);
    @(negedge clock);
    chk("midreset rdv2 late", {31'h0, rvalid2}, 32'h0);
    reset_n = 1'b1;
    rd_chk("post reset ctrl", 4'd3, 32'h0);
    rd_chk("post reset hi", 4'd5, 32'h0);
    rd_chk("post reset scr0", 4'd6, 32'h0);
    rd_chk("post reset scr3", 4'd9, 32'h0);

    idle(3);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
